// File: rtl/arm_multicycle_ctrl_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle controller.
// The master side is the datapath and the slave side is the controller.
interface arm_multicycle_ctrl_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [2:0] ALUControl;

    modport master (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );

    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );
endinterface

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM-subset controller: Moore FSM plus registered NZCV flags and condition check.
// Optional macro CTRL_CMPTST_EN: CMP/TST execute as SUB/AND, always set flags, and skip ALUWB.
module arm_multicycle_ctrl (
    input  logic                 clk,
    input  logic                 reset,
    arm_multicycle_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex;
    logic [3:0] cmd;
    logic [2:0] alu_dp;
    logic       is_cmptst;
    logic       flag_upd;

    logic       pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a;
    logic [1:0] result_src, alu_src_b, imm_src, reg_src;
    logic [2:0] alu_control;

    // Flags are {N,Z,C,V}; 1111 is treated as "never".
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = ~z;
            4'b0010: cond_eval = cf;
            4'b0011: cond_eval = ~cf;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = ~n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = ~v;
            4'b1000: cond_eval = cf & ~z;
            4'b1001: cond_eval = ~cf | z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = ~z & (n == v);
            4'b1101: cond_eval = z | (n != v);
            4'b1110: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    assign cond_ex = cond_eval(bus.Cond, flags_q);
    assign cmd     = bus.Funct[4:1];

`ifdef CTRL_CMPTST_EN
    assign is_cmptst = (cmd == 4'b1010) || (cmd == 4'b1000);
`else
    assign is_cmptst = 1'b0;
`endif

    always_comb begin
        alu_dp = 3'b000;
        case (cmd)
            4'b0100: alu_dp = 3'b000;
            4'b0010: alu_dp = 3'b001;
            4'b0000: alu_dp = 3'b010;
            4'b1100: alu_dp = 3'b011;
`ifdef CTRL_CMPTST_EN
            4'b1010: alu_dp = 3'b001;
            4'b1000: alu_dp = 3'b010;
`endif
            default: alu_dp = 3'b000;
        endcase
    end

    assign flag_upd = cond_ex & (bus.Funct[0] | is_cmptst);

    // Logical ops (AND/ORR share alu_dp[1]) leave C and V untouched.
    always_comb begin
        flags_d = flags_q;
        if (((state_q == EXECR) || (state_q == EXECI)) && flag_upd) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
            if (!alu_dp[1])
                flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        imm_src     = bus.Op;
        reg_src     = 2'b00;
        alu_control = 3'b000;
        case (state_q)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (bus.Op)
                    2'b00:   state_d = bus.Funct[5] ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                alu_src_b   = 2'b01;
                alu_control = bus.Funct[3] ? 3'b000 : 3'b001;
                state_d     = bus.Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                adr_src    = 1'b1;
                result_src = 2'b01;
                reg_write  = cond_ex;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = cond_ex;
                state_d   = FETCH;
            end
            EXECR, EXECI: begin
                alu_src_b   = (state_q == EXECI) ? 2'b01 : 2'b00;
                alu_control = alu_dp;
                state_d     = is_cmptst ? FETCH : ALUWB;
            end
            ALUWB: begin
                if (bus.Rd == 4'd15)
                    pc_write = cond_ex;
                else
                    reg_write = cond_ex;
                state_d = FETCH;
            end
            BRANCH: begin
                reg_src    = 2'b01;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = cond_ex;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Strobes are masked by reset so nothing is written while FETCH is forced.
    assign bus.PCWrite    = pc_write  & ~reset;
    assign bus.MemWrite   = mem_write & ~reset;
    assign bus.RegWrite   = reg_write & ~reset;
    assign bus.IRWrite    = ir_write  & ~reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ImmSrc     = imm_src;
    assign bus.RegSrc     = reg_src;
    assign bus.ALUControl = alu_control;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed table-driven bench for arm_multicycle_ctrl: one row per clock cycle,
// followed by hand-written reset checks around a store.
module tb_arm_multicycle_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    arm_multicycle_ctrl_if bus ();

    arm_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [3:0]  rd;
        logic [3:0]  af;
        logic [16:0] exp;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs[$];

    // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegSrc,ALUControl}
    function automatic logic [16:0] o(input logic pcw, input logic mw, input logic rw,
                                      input logic irw, input logic adr, input logic [1:0] res,
                                      input logic asa, input logic [1:0] asb, input logic [1:0] imm,
                                      input logic [1:0] rs, input logic [2:0] alu);
        return {pcw, mw, rw, irw, adr, res, asa, asb, imm, rs, alu};
    endfunction

    function automatic logic [16:0] outs();
        return {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc, bus.ALUControl};
    endfunction

    task automatic add(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                       input logic [3:0] rd, input logic [3:0] af, input logic [16:0] e,
                       input logic [3:0] fl);
        vec_t v;
        v.cond = c; v.op = op; v.fn = fn; v.rd = rd; v.af = af; v.exp = e; v.fl = fl;
        vecs.push_back(v);
    endtask

    // FETCH and DECODE rows of one instruction.
    task automatic fd(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                      input logic [3:0] rd, input logic [3:0] fl);
        add(c, op, fn, rd, 4'h0, o(1,0,0,1,0,2'b10,1,2'b10,op,2'b00,3'b000), fl);
        add(c, op, fn, rd, 4'h0, o(0,0,0,0,0,2'b10,1,2'b10,op,2'b00,3'b000), fl);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    logic [3:0] fl_end;

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'b0; bus.Rd = 4'd0; bus.ALUFlags = 4'h0;

        // ADDS R1,R2,#1 (flags <- 0110)
        fd(4'hE, 2'b00, 6'b101001, 4'd1, 4'h0);
        add(4'hE, 2'b00, 6'b101001, 4'd1, 4'h6, o(0,0,0,0,0,2'b00,0,2'b01,2'b00,2'b00,3'b000), 4'h0);
        add(4'hE, 2'b00, 6'b101001, 4'd1, 4'h0, o(0,0,1,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000), 4'h6);
        // LDR R3,[R4,#-8]
        fd(4'hE, 2'b01, 6'b010001, 4'd3, 4'h6);
        add(4'hE, 2'b01, 6'b010001, 4'd3, 4'h0, o(0,0,0,0,0,2'b00,0,2'b01,2'b01,2'b00,3'b001), 4'h6);
        add(4'hE, 2'b01, 6'b010001, 4'd3, 4'h0, o(0,0,0,0,1,2'b00,0,2'b00,2'b01,2'b00,3'b000), 4'h6);
        add(4'hE, 2'b01, 6'b010001, 4'd3, 4'h0, o(0,0,1,0,1,2'b01,0,2'b00,2'b01,2'b00,3'b000), 4'h6);
        // STR R5,[..,#+imm]
        fd(4'hE, 2'b01, 6'b011000, 4'd5, 4'h6);
        add(4'hE, 2'b01, 6'b011000, 4'd5, 4'h0, o(0,0,0,0,0,2'b00,0,2'b01,2'b01,2'b00,3'b000), 4'h6);
        add(4'hE, 2'b01, 6'b011000, 4'd5, 4'h0, o(0,1,0,0,1,2'b00,0,2'b00,2'b01,2'b00,3'b000), 4'h6);
        // BEQ with Z=1: taken
        fd(4'h0, 2'b10, 6'b000000, 4'd0, 4'h6);
        add(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, o(1,0,0,0,0,2'b10,0,2'b01,2'b10,2'b01,3'b000), 4'h6);
        // ADDS R0,R0,R0 (flags <- 0011)
        fd(4'hE, 2'b00, 6'b001001, 4'd0, 4'h6);
        add(4'hE, 2'b00, 6'b001001, 4'd0, 4'h3, o(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000), 4'h6);
        add(4'hE, 2'b00, 6'b001001, 4'd0, 4'h0, o(0,0,1,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000), 4'h3);
        // BEQ with Z=0: not taken
        fd(4'h0, 2'b10, 6'b000000, 4'd0, 4'h3);
        add(4'h0, 2'b10, 6'b000000, 4'd0, 4'h0, o(0,0,0,0,0,2'b10,0,2'b01,2'b10,2'b01,3'b000), 4'h3);
        // ANDS with ALUFlags=1000: NZ written, CV held -> 1011
        fd(4'hE, 2'b00, 6'b000001, 4'd2, 4'h3);
        add(4'hE, 2'b00, 6'b000001, 4'd2, 4'h8, o(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b010), 4'h3);
        add(4'hE, 2'b00, 6'b000001, 4'd2, 4'h0, o(0,0,1,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000), 4'hB);
        // ORRLT with N=V: suppressed
        fd(4'hB, 2'b00, 6'b011000, 4'd4, 4'hB);
        add(4'hB, 2'b00, 6'b011000, 4'd4, 4'h5, o(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b011), 4'hB);
        add(4'hB, 2'b00, 6'b011000, 4'd4, 4'h0, o(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000), 4'hB);
        // SUBGT with Z=0, N=V: executes
        fd(4'hC, 2'b00, 6'b000100, 4'd6, 4'hB);
        add(4'hC, 2'b00, 6'b000100, 4'd6, 4'h0, o(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b001), 4'hB);
        add(4'hC, 2'b00, 6'b000100, 4'd6, 4'h0, o(0,0,1,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000), 4'hB);
        // ADD PC,...: ALUWB writes PC instead of a register
        fd(4'hE, 2'b00, 6'b001000, 4'd15, 4'hB);
        add(4'hE, 2'b00, 6'b001000, 4'd15, 4'h0, o(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000), 4'hB);
        add(4'hE, 2'b00, 6'b001000, 4'd15, 4'h0, o(1,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000), 4'hB);
        // Cond 1111 ADDS: no write, no flag change
        fd(4'hF, 2'b00, 6'b001001, 4'd1, 4'hB);
        add(4'hF, 2'b00, 6'b001001, 4'd1, 4'h4, o(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000), 4'hB);
        add(4'hF, 2'b00, 6'b001001, 4'd1, 4'h0, o(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000), 4'hB);
        // Undefined Op: 2 cycles
        fd(4'hE, 2'b11, 6'b000000, 4'd0, 4'hB);
        // cmd 1010 with S=0, ALUFlags=0100
        fd(4'hE, 2'b00, 6'b010100, 4'd2, 4'hB);
`ifdef CTRL_CMPTST_EN
        add(4'hE, 2'b00, 6'b010100, 4'd2, 4'h4, o(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b001), 4'hB);
        fd(4'h1, 2'b10, 6'b000000, 4'd0, 4'h4);
        add(4'h1, 2'b10, 6'b000000, 4'd0, 4'h0, o(0,0,0,0,0,2'b10,0,2'b01,2'b10,2'b01,3'b000), 4'h4);
        fd(4'hE, 2'b11, 6'b000000, 4'd0, 4'h4);
        fl_end = 4'h4;
`else
        add(4'hE, 2'b00, 6'b010100, 4'd2, 4'h4, o(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000), 4'hB);
        add(4'hE, 2'b00, 6'b010100, 4'd2, 4'h0, o(0,0,1,0,0,2'b00,0,2'b00,2'b00,2'b00,3'b000), 4'hB);
        fd(4'h1, 2'b10, 6'b000000, 4'd0, 4'hB);
        add(4'h1, 2'b10, 6'b000000, 4'd0, 4'h0, o(1,0,0,0,0,2'b10,0,2'b01,2'b10,2'b01,3'b000), 4'hB);
        fd(4'hE, 2'b11, 6'b000000, 4'd0, 4'hB);
        fl_end = 4'hB;
`endif

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset PCWrite", 32'(bus.PCWrite), 32'd0);
        chk("reset IRWrite", 32'(bus.IRWrite), 32'd0);
        chk("reset state", 32'(dut.state_q), 32'd0);
        chk("reset flags", 32'(dut.flags_q), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.Cond = vecs[i].cond; bus.Op = vecs[i].op; bus.Funct = vecs[i].fn;
            bus.Rd = vecs[i].rd; bus.ALUFlags = vecs[i].af;
            @(negedge clk);
            chk($sformatf("row%0d outs", i), 32'(outs()), 32'(vecs[i].exp));
            chk($sformatf("row%0d flags", i), 32'(dut.flags_q), 32'(vecs[i].fl));
            @(posedge clk);
            #1;
        end

        // STR up to MEMWRITE, then reset mid-cycle
        bus.Cond = 4'hE; bus.Op = 2'b01; bus.Funct = 6'b011000; bus.Rd = 4'd5; bus.ALUFlags = 4'h0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("memwrite before reset", 32'(bus.MemWrite), 32'd1);
        chk("flags before reset", 32'(dut.flags_q), 32'(fl_end));
        #2 reset = 1'b1;
        #1;
        chk("mid reset MemWrite", 32'(bus.MemWrite), 32'd0);
        chk("mid reset PCWrite", 32'(bus.PCWrite), 32'd0);
        chk("mid reset state", 32'(dut.state_q), 32'd0);
        chk("mid reset flags", 32'(dut.flags_q), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("after release outs", 32'(outs()), 32'(o(1,0,0,1,0,2'b10,1,2'b10,2'b01,2'b00,3'b000)));
        @(posedge clk);
        #1;
        chk("first edge decode outs", 32'(outs()), 32'(o(0,0,0,0,0,2'b10,1,2'b10,2'b01,2'b00,3'b000)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
